// File: rtl/system_0_sysid_arbiter.sv
// system_0_sysid_arbiter
//
// Shares the single-word-select system-ID Avalon-MM slave between two
// read-only masters. After reset an optional self-check reads the ID word
// and the build-timestamp word and compares them with the expected values.
// Both masters stall until that check is finished.
//
// Ports
//   clock, reset_n            system clock, asynchronous active-low reset
//   m0_* / m1_*               Avalon-MM read-only slave ports for master 0 / 1
//     mX_address              word select (0 = ID, 1 = timestamp)
//     mX_read                 read request
//     mX_waitrequest          stall, combinational
//     mX_readdata             registered read data, held until next capture
//     mX_readdatavalid        one-cycle pulse when mX_readdata is fresh
//   sysid_address             registered word select to the sysid slave
//   sysid_readdata            combinational data from the sysid slave
//   boot_done                 self-check finished (or skipped)
//   id_ok / id_mismatch       self-check result, held until reset

module system_0_sysid_arbiter #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5D2F8C3C,
  parameter bit          BOOT_CHECK         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        m0_address,
  input  logic        m0_read,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,

  input  logic        m1_address,
  input  logic        m1_read,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,

  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,

  output logic        boot_done,
  output logic        id_ok,
  output logic        id_mismatch
);

  typedef enum logic [1:0] {
    StBootA0,
    StBootA1,
    StIdle,
    StRead
  } state_e;

  localparam state_e ResetState = BOOT_CHECK ? StBootA0 : StIdle;

  state_e      state_q, state_d;
  logic        sysid_address_q, sysid_address_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        id0_match_q, id0_match_d;
  logic [31:0] m0_readdata_q, m0_readdata_d;
  logic [31:0] m1_readdata_q, m1_readdata_d;
  logic        m0_rdv_q, m0_rdv_d;
  logic        m1_rdv_q, m1_rdv_d;
  logic        boot_done_q, boot_done_d;
  logic        id_ok_q, id_ok_d;
  logic        id_mismatch_q, id_mismatch_d;

  logic        grant_valid;
  logic        grant;
  logic        ts_match;

  // Arbitration is only live in IDLE; on contention the master that did not
  // win last time gets the slot (last_grant resets to 1 so master 0 goes first).
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (state_q == StIdle) begin
      case ({m1_read, m0_read})
        2'b01: begin
          grant_valid = 1'b1;
          grant       = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant       = 1'b1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant       = ~last_grant_q;
        end
        default: begin
          grant_valid = 1'b0;
          grant       = 1'b0;
        end
      endcase
    end
  end

  assign m0_waitrequest = ~(grant_valid & ~grant);
  assign m1_waitrequest = ~(grant_valid & grant);

  assign ts_match = (sysid_readdata == EXPECTED_TIMESTAMP);

  always_comb begin
    state_d         = state_q;
    sysid_address_d = sysid_address_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    id0_match_d     = id0_match_q;
    m0_readdata_d   = m0_readdata_q;
    m1_readdata_d   = m1_readdata_q;
    m0_rdv_d        = 1'b0;
    m1_rdv_d        = 1'b0;
    boot_done_d     = boot_done_q;
    id_ok_d         = id_ok_q;
    id_mismatch_d   = id_mismatch_q;

    case (state_q)
      StBootA0: begin
        id0_match_d     = (sysid_readdata == EXPECTED_ID);
        sysid_address_d = 1'b1;
        state_d         = StBootA1;
      end
      StBootA1: begin
        id_ok_d       = id0_match_q & ts_match;
        id_mismatch_d = ~(id0_match_q & ts_match);
        boot_done_d   = 1'b1;
        state_d       = StIdle;
      end
      StIdle: begin
        if (grant_valid) begin
          sysid_address_d = grant ? m1_address : m0_address;
          owner_d         = grant;
          last_grant_d    = grant;
          state_d         = StRead;
        end
      end
      StRead: begin
        // Slave data is combinational, so the address registered at accept
        // has had the whole READ cycle to settle.
        if (owner_q) begin
          m1_readdata_d = sysid_readdata;
          m1_rdv_d      = 1'b1;
        end else begin
          m0_readdata_d = sysid_readdata;
          m0_rdv_d      = 1'b1;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = ResetState;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ResetState;
      sysid_address_q <= 1'b0;
      owner_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      id0_match_q     <= 1'b0;
      m0_readdata_q   <= 32'd0;
      m1_readdata_q   <= 32'd0;
      m0_rdv_q        <= 1'b0;
      m1_rdv_q        <= 1'b0;
      boot_done_q     <= ~BOOT_CHECK;
      id_ok_q         <= 1'b0;
      id_mismatch_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      sysid_address_q <= sysid_address_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      id0_match_q     <= id0_match_d;
      m0_readdata_q   <= m0_readdata_d;
      m1_readdata_q   <= m1_readdata_d;
      m0_rdv_q        <= m0_rdv_d;
      m1_rdv_q        <= m1_rdv_d;
      boot_done_q     <= boot_done_d;
      id_ok_q         <= id_ok_d;
      id_mismatch_q   <= id_mismatch_d;
    end
  end

  assign sysid_address    = sysid_address_q;
  assign m0_readdata      = m0_readdata_q;
  assign m1_readdata      = m1_readdata_q;
  assign m0_readdatavalid = m0_rdv_q;
  assign m1_readdatavalid = m1_rdv_q;
  assign boot_done        = boot_done_q;
  assign id_ok            = id_ok_q;
  assign id_mismatch      = id_mismatch_q;

endmodule

// File: doc/system_0_sysid_arbiter.md
# system_0_sysid_arbiter

Shares the system-ID Avalon-MM slave (1-bit address, 32-bit combinational readdata: word 0 = ID, word 1 = build timestamp) between two read-only masters, such as the Nios CPU and the Ethernet host-management path. After reset it runs a self-check sequence that reads both words and compares them against expected values. Until that check completes, both masters are stalled. It sits between the interconnect masters and the sysid slave, and exports boot-status flags to the system-ready logic.

## Interface
- EXPECTED_ID, 0, value word 0 must return
- EXPECTED_TIMESTAMP, 1563397180 (0x5D2F8C3C), value word 1 must return
- BOOT_CHECK, 1, 1 = run self-check after reset; 0 = skip it and go straight to IDLE
- clock  in  1  single system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_address  in  1  master 0 word select
- m0_read  in  1  master 0 read request
- m0_waitrequest  out  1  master 0 stall (combinational)
- m0_readdata  out  32  master 0 read data (registered)
- m0_readdatavalid  out  1  one-cycle pulse when m0_readdata is valid
- m1_address, m1_read, m1_waitrequest, m1_readdata, m1_readdatavalid: same as master 0, for master 1
- sysid_address  out  1  registered address to the sysid slave
- sysid_readdata  in  32  combinational data from the sysid slave
- boot_done  out  1  self-check finished (or skipped)
- id_ok  out  1  both words matched
- id_mismatch  out  1  at least one word differed

## Operation
- States: BOOT_A0, BOOT_A1, IDLE, READ.
- Reset state:
  - BOOT_A0 if BOOT_CHECK=1, else IDLE.
  - sysid_address=0, mX_readdata=0, mX_readdatavalid=0, owner=0, last_grant=1.
  - id_ok=0, id_mismatch=0, boot_done=!BOOT_CHECK.
- BOOT_A0: at the edge, sample sysid_readdata and store (== EXPECTED_ID) in a match flag. Set sysid_address<=1 and go to BOOT_A1.
- BOOT_A1: at the edge, compare sysid_readdata against EXPECTED_TIMESTAMP.
  - Set id_ok<=both matched, id_mismatch<=!id_ok, boot_done<=1.
  - Go to IDLE. Flags then hold until reset.
- IDLE grant, combinational:
  - Only one of m0_read, m1_read high: that master is granted.
  - Both high: the master other than last_grant is granted.
  - Neither high: no grant.
- mX_waitrequest = !(state==IDLE && grant==X). It is high in every boot state and in READ.
- Accept happens when mX_read && !mX_waitrequest. At the edge:
  - sysid_address<=mX_address, owner<=X, last_grant<=X.
  - Go to READ.
- READ: at the edge, capture sysid_readdata into the owner's readdata register only. Pulse the owner's readdatavalid for the following cycle and go to IDLE.
- Each master's readdata holds its last captured value until its next capture.
- A non-granted master holding m_read stays stalled. It is served at the next IDLE in which it wins arbitration; round-robin guarantees service within one intervening transaction.
- Reset asserted mid-operation: immediate return to reset values. An in-flight read is dropped and produces no readdatavalid; the master must reissue it.

## Timing
- Boot: boot_done, id_ok and id_mismatch become valid after the 2nd rising edge following reset_n release. Masters are stalled until then.
- Read latency: accept in cycle N; readdatavalid high in cycle N+2 only, with data valid in the same cycle.
- Throughput: one read per 2 cycles. A new accept is possible in cycle N+2, concurrent with readdatavalid.
- sysid_address is stable from cycle N+1 through the capture edge at the end of N+1.
- mX_readdatavalid is never high for both masters in the same cycle. It is never high while reset_n=0.

## Test plan
- Defaults, release reset → boot_done=1 and id_ok=1, id_mismatch=0 after 2 edges. m0/m1 waitrequest stays high until then.
- EXPECTED_ID=5 → boot_done=1, id_ok=0, id_mismatch=1. Reads still serviced afterwards.
- m0 reads address 1, accepted in cycle N → m0_readdatavalid only in N+2, m0_readdata=0x5D2F8C3C; m1 outputs unchanged.
- m0 and m1 request simultaneously, held continuously → grants alternate m0, m1, m0, m1 (m0 first after reset). Each pulse carries the correct word (address 0 → 0x00000000).
- m1 holds read through an m0 transaction → m1 is accepted in cycle N+2 and its readdatavalid arrives in N+4.
- reset_n pulsed low in READ → no readdatavalid, all outputs return to reset values, and boot re-runs.
